// File: rtl/rv_pkg.sv
// rv_pkg: width helpers shared by the srdy/rrdy elastic buffer blocks
package rv_pkg;
  function automatic int rv_ptr_w(input int depth);
    return $clog2(depth) > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int rv_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/elastic_fifo_nd_if.sv
// elastic_fifo_nd_if: srdy/rrdy producer+consumer bundle for elastic_fifo_nd
// slave = buffer side; master = producer/consumer side.
// in_srdy/in_data/in_rrdy: input beat; out_srdy/out_data/out_rrdy: output beat;
// count: occupancy; flush exists only with ELASTIC_FIFO_FLUSH_EN.
interface elastic_fifo_nd_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  import rv_pkg::*;
  logic in_srdy;
  logic [WIDTH-1:0] in_data;
  logic in_rrdy;
  logic out_rrdy;
  logic out_srdy;
  logic [WIDTH-1:0] out_data;
  logic [rv_cnt_w(DEPTH)-1:0] count;
`ifdef ELASTIC_FIFO_FLUSH_EN
  logic flush;
  modport slave(input in_srdy, in_data, out_rrdy, flush, output in_rrdy, out_srdy, out_data, count);
  modport master(output in_srdy, in_data, out_rrdy, flush, input in_rrdy, out_srdy, out_data, count);
`else
  modport slave(input in_srdy, in_data, out_rrdy, output in_rrdy, out_srdy, out_data, count);
  modport master(output in_srdy, in_data, out_rrdy, input in_rrdy, out_srdy, out_data, count);
`endif
endinterface

// File: rtl/elastic_fifo_ptr.sv
// elastic_fifo_ptr: pointer over 0..DEPTH-1 with explicit wrap, inc and clr
// clk/rst_n: clock, async active-low reset; inc: advance; clr: return to 0 (wins over inc); ptr: value.
module elastic_fifo_ptr
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic [rv_ptr_w(DEPTH)-1:0] ptr
);
  localparam int PW = rv_ptr_w(DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr == PW'(DEPTH - 1) ? '0 : ptr + PW'(1);
endmodule

// File: rtl/elastic_fifo_nd.sv
// elastic_fifo_nd: DEPTH-entry WIDTH-bit srdy/rrdy elastic buffer at full throughput
// clk: rising-edge clock; rst_n: async active-low reset;
// b: elastic_fifo_nd_if.slave (in_srdy/in_data/in_rrdy, out_srdy/out_data/out_rrdy, count).
// Define ELASTIC_FIFO_FLUSH_EN to add the flush input.
module elastic_fifo_nd
  import rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  elastic_fifo_nd_if.slave b
);
  localparam int PW = rv_ptr_w(DEPTH);
  localparam int CW = rv_cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic fl, push, pop;
`ifdef ELASTIC_FIFO_FLUSH_EN
  assign fl = b.flush;
`else
  assign fl = 1'b0;
`endif
  // when full, a pop frees the slot this same edge, so readiness follows out_rrdy
  assign b.in_rrdy = (cnt != CW'(DEPTH) || b.out_rrdy) && !fl;
  assign b.out_srdy = cnt != '0 && !fl;
  assign b.out_data = mem[rd_ptr];
  assign b.count = cnt;
  assign push = b.in_srdy && b.in_rrdy;
  assign pop = b.out_srdy && b.out_rrdy;
  elastic_fifo_ptr #(.DEPTH(DEPTH)) u_wr (.clk, .rst_n, .inc(push), .clr(fl), .ptr(wr_ptr));
  elastic_fifo_ptr #(.DEPTH(DEPTH)) u_rd (.clk, .rst_n, .inc(pop), .clr(fl), .ptr(rd_ptr));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= b.in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (fl) cnt <= '0;
    else if (push && !pop) cnt <= cnt + CW'(1);
    else if (pop && !push) cnt <= cnt - CW'(1);
endmodule

// File: tb/tb_elastic_fifo_nd.sv
// tb_elastic_fifo_nd: directed DEPTH=4 checks plus randomized DEPTH=3/5 queue-model runs
module tb_elastic_fifo_nd;
  logic clk = 0;
  logic rst_n = 0;
  int tests = 0;
  int fails = 0;
  bit go = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  elastic_fifo_nd_if #(.WIDTH(8), .DEPTH(4)) b4();
  elastic_fifo_nd #(.WIDTH(8), .DEPTH(4)) u4 (.clk, .rst_n, .b(b4.slave));

  for (genvar g = 0; g < 2; g++) begin : r
    localparam int D = g ? 5 : 3;
    bit fin = 0;
    logic [7:0] q[$];
    elastic_fifo_nd_if #(.WIDTH(8), .DEPTH(D)) b();
    elastic_fifo_nd #(.WIDTH(8), .DEPTH(D)) dut (.clk, .rst_n, .b(b.slave));
    initial begin
      int pops = 0;
      bit push, pop;
      b.in_srdy = 0;
      b.in_data = 0;
      b.out_rrdy = 0;
`ifdef ELASTIC_FIFO_FLUSH_EN
      b.flush = 0;
`endif
      wait (go);
      for (int c = 0; c < 20000 && pops < 2000; c++) begin
        @(negedge clk);
        b.in_srdy = 1'($urandom);
        b.in_data = 8'($urandom);
        b.out_rrdy = 1'($urandom);
        #1;
        chk($sformatf("rnd%0d_count", D), 32'(b.count), 32'(q.size()));
        chk($sformatf("rnd%0d_out_srdy", D), 32'(b.out_srdy), 32'(q.size() != 0));
        chk($sformatf("rnd%0d_in_rrdy", D), 32'(b.in_rrdy), 32'(q.size() != D || b.out_rrdy));
        pop = b.out_rrdy && q.size() != 0;
        push = b.in_srdy && (q.size() != D || b.out_rrdy);
        if (pop) begin
          chk($sformatf("rnd%0d_data", D), 32'(b.out_data), 32'(q[0]));
          void'(q.pop_front());
          pops++;
        end
        if (push) q.push_back(b.in_data);
      end
      chk($sformatf("rnd%0d_beats", D), 32'(pops), 32'd2000);
      @(negedge clk);
      b.in_srdy = 0;
      b.out_rrdy = 0;
      fin = 1;
    end
  end

  initial begin
    b4.in_srdy = 0;
    b4.in_data = 0;
    b4.out_rrdy = 0;
`ifdef ELASTIC_FIFO_FLUSH_EN
    b4.flush = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(b4.count), 0);
    chk("rst_out_srdy", 32'(b4.out_srdy), 0);
    chk("rst_in_rrdy", 32'(b4.in_rrdy), 1);
    rst_n = 1;
    @(negedge clk);
    // first push visible one edge later
    b4.in_srdy = 1;
    b4.in_data = 8'h11;
    @(negedge clk);
    b4.in_srdy = 0;
    chk("t1_out_srdy", 32'(b4.out_srdy), 1);
    chk("t1_out_data", 32'(b4.out_data), 32'h11);
    chk("t1_count", 32'(b4.count), 1);
    b4.out_rrdy = 1;
    @(negedge clk);
    b4.out_rrdy = 0;
    chk("t1_empty", 32'(b4.count), 0);
    // fill, then a held fifth beat
    for (int k = 0; k < 5; k++) begin
      b4.in_srdy = 1;
      b4.in_data = 8'(8'hA0 + k);
      @(negedge clk);
    end
    chk("t2_count", 32'(b4.count), 4);
    chk("t2_in_rrdy", 32'(b4.in_rrdy), 0);
    b4.in_srdy = 0;
    b4.out_rrdy = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_srdy", 32'(b4.out_srdy), 1);
      chk("t2_drain_data", 32'(b4.out_data), 32'hA0 + 32'(k));
      @(negedge clk);
    end
    chk("t2_empty_srdy", 32'(b4.out_srdy), 0);
    chk("t2_empty_count", 32'(b4.count), 0);
    b4.out_rrdy = 0;
    // full streaming across pointer wrap
    for (int k = 0; k < 4; k++) begin
      b4.in_srdy = 1;
      b4.in_data = 8'(8'hB0 + k);
      @(negedge clk);
    end
    b4.out_rrdy = 1;
    for (int k = 0; k < 8; k++) begin
      b4.in_data = 8'(8'hB4 + k);
      #1;
      chk("t3_in_rrdy", 32'(b4.in_rrdy), 1);
      chk("t3_count", 32'(b4.count), 4);
      chk("t3_data", 32'(b4.out_data), 32'hB0 + 32'(k));
      @(negedge clk);
    end
    b4.in_srdy = 0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_tail", 32'(b4.out_data), 32'hB8 + 32'(k));
      @(negedge clk);
    end
    chk("t3_empty", 32'(b4.count), 0);
    b4.out_rrdy = 0;
    // randomized runs on DEPTH=3 and DEPTH=5
    go = 1;
    for (int c = 0; c < 45000 && !(r[0].fin && r[1].fin); c++) @(negedge clk);
    chk("rnd_done", 32'(r[0].fin && r[1].fin), 1);
    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      b4.in_srdy = 1;
      b4.in_data = 8'(8'hC0 + k);
      @(negedge clk);
    end
    b4.in_srdy = 0;
    chk("t5_count_pre", 32'(b4.count), 3);
    #2 rst_n = 0;
    #1;
    chk("t5_async_count", 32'(b4.count), 0);
    chk("t5_async_srdy", 32'(b4.out_srdy), 0);
    @(negedge clk);
    rst_n = 1;
    b4.in_srdy = 1;
    b4.in_data = 8'hD1;
    @(negedge clk);
    b4.in_data = 8'hD2;
    @(negedge clk);
    b4.in_srdy = 0;
    b4.out_rrdy = 1;
    chk("t5_first", 32'(b4.out_data), 32'hD1);
    @(negedge clk);
    chk("t5_second", 32'(b4.out_data), 32'hD2);
    @(negedge clk);
    chk("t5_empty", 32'(b4.count), 0);
    b4.out_rrdy = 0;
`ifdef ELASTIC_FIFO_FLUSH_EN
    for (int k = 0; k < 2; k++) begin
      b4.in_srdy = 1;
      b4.in_data = 8'(8'h50 + k);
      @(negedge clk);
    end
    chk("t6_count_pre", 32'(b4.count), 2);
    b4.flush = 1;
    b4.in_data = 8'h77;
    #1;
    chk("t6_in_rrdy", 32'(b4.in_rrdy), 0);
    chk("t6_out_srdy", 32'(b4.out_srdy), 0);
    @(negedge clk);
    b4.flush = 0;
    b4.in_srdy = 0;
    chk("t6_count", 32'(b4.count), 0);
    b4.in_srdy = 1;
    b4.in_data = 8'h5C;
    @(negedge clk);
    b4.in_srdy = 0;
    chk("t6_first", 32'(b4.out_data), 32'h5C);
    chk("t6_count_post", 32'(b4.count), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
